time_keeper: RTL
================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25_000_000, clk cycles per second.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250_000, stable cycles needed to accept a button level.
REQ-003 SHALL have parameter RING_SECS, default 60, the alarm auto-stop timeout in seconds.
REQ-004 SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- btn_hour  in  1  raw async button, advances hour
- btn_min  in  1  raw async button, advances minute
- btn_al_hour  in  1  raw async button, advances alarm hour
- btn_al_min  in  1  raw async button, advances alarm minute by 10
- btn_alarm  in  1  raw async button, toggles alarm_en or acknowledges a ring
- hour  out  4  0..11
- minute  out  6  0..59
- second  out  6  0..59
- al_hour  out  4  0..11
- al_minute  out  6  0,10..50
- slow_clk  out  1  1 Hz square wave for the renderer
- tick_1hz  out  1  one-cycle pulse per second
- alarm_en  out  1  alarm armed
- alarm_ring  out  1  alarm sounding

Function
REQ-005 SHALL count a prescaler 0..CLK_HZ-1; tick_1hz SHALL pulse on the cycle the count is CLK_HZ-1, then the count wraps to 0.
REQ-006 slow_clk SHALL be high while prescaler < CLK_HZ/2, else low; it is registered, so it rises one cycle after the tick.
REQ-007 On a tick: second +1 mod 60; at 59->0, minute +1 mod 60; at minute 59->0 as well, hour +1 mod 12.
REQ-008 Each button SHALL pass through a 2-FF synchronizer and a debouncer.
- The debounced level changes only after DEBOUNCE_CYCLES consecutive identical samples.
- A one-cycle press pulse fires on each debounced 0->1 transition; holding a button produces no repeat.
REQ-009 Minute press SHALL compute minute = (minute + tick_carry + 1) mod 60, with no carry into hour.
- tick_carry is 1 only when a tick occurs with second==59.
- Hour press SHALL compute hour = (hour + minute_carry + 1) mod 12.
- second SHALL be unaffected by either press.
REQ-010 al_hour press: +1 mod 12. al_minute press: +10, 50->0, with no carry.
REQ-011 The alarm FSM SHALL have states IDLE and RING; alarm_ring=1 only in RING.
REQ-012 IDLE->RING on a tick whose post-update time has hour==al_hour, minute==al_minute, second==0, while alarm_en=1.
REQ-013 RING->IDLE on a btn_alarm press (alarm_en stays 1), after RING_SECS ticks in RING, or when alarm_en is cleared.
REQ-014 In IDLE, a btn_alarm press SHALL toggle alarm_en; in RING it SHALL only acknowledge the ring.
REQ-015 A btn_alarm press on the same cycle as the matching tick SHALL take priority: the FSM stays in IDLE and alarm_en toggles.
REQ-016 Time edits SHALL NOT trigger the alarm; only a tick can.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 On asserting rst_n=0, outputs SHALL clear asynchronously:
- hour, minute, second, al_hour, al_minute = 0
- slow_clk, tick_1hz, alarm_en, alarm_ring = 0
- FSM = IDLE; prescaler, ring counter, debouncers and synchronizers = 0
REQ-019 After rst_n deasserts, the first tick SHALL occur CLK_HZ cycles after the first clk edge.
REQ-020 Reset mid-ring or mid-debounce SHALL abandon all state; no stale press pulse is emitted afterwards.

Structure
REQ-021 A shared package clock_pkg SHALL hold:
- widths HOUR_W=4, MIN_W=6
- constants HOURS_PER_DIAL=12, MINS_PER_HOUR=60, AL_MIN_STEP=10
- the alarm state encoding ALARM_IDLE=0, ALARM_RING=1
REQ-022 Sub-module button_debounce (sync + debounce + edge pulse) SHALL be instantiated five times.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4, RING_SECS=3)
REQ-023 Reset, then run 10 cycles -> exactly one tick_1hz at cycle 10; slow_clk high for cycles 1..5.
REQ-024 Preload 11:59:58 via presses, run 2 ticks -> 00:00:00, with no extra hour increment.
REQ-025 Bounce btn_min 0/1 every 2 cycles for 20 cycles, then hold 1 -> minute +1 exactly once.
REQ-026 Set al 3:20, alarm_en=1, time 3:19:59, one tick -> alarm_ring=1; after 3 ticks -> 0, alarm_en still 1.
REQ-027 Ring active, press btn_alarm -> ring drops within DEBOUNCE_CYCLES+3 cycles; alarm_en=1.
REQ-028 Ring active, pull rst_n low for 1 cycle -> all outputs 0 immediately; no ring after release.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared dial widths, dial constants and alarm state encoding
package clock_pkg;
  localparam int HOUR_W = 4;
  localparam int MIN_W = 6;
  localparam int HOURS_PER_DIAL = 12;
  localparam int MINS_PER_HOUR = 60;
  localparam int AL_MIN_STEP = 10;
  localparam int WRAP_W = 7;

  typedef enum logic {
    ALARM_IDLE = 1'b0,
    ALARM_RING = 1'b1
  } alarm_state_t;

  // Operands never exceed one modulus, so a single conditional subtract wraps.
  function automatic logic [WRAP_W-1:0] wrap_add(input logic [WRAP_W-1:0] value,
                                                 input logic [WRAP_W-1:0] inc,
                                                 input logic [WRAP_W-1:0] modulus);
    logic [WRAP_W-1:0] sum;
    sum = value + inc;
    return (sum >= modulus) ? sum - modulus : sum;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchronizer, level debouncer and rising-edge press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_b;
        press <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 12-hour clock with settable time, 10-minute-step alarm and ring FSM
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ          = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int RING_SECS       = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_hour,
  input  logic              btn_min,
  input  logic              btn_al_hour,
  input  logic              btn_al_min,
  input  logic              btn_alarm,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [MIN_W-1:0]  second,
  output logic [HOUR_W-1:0] al_hour,
  output logic [MIN_W-1:0]  al_minute,
  output logic              slow_clk,
  output logic              tick_1hz,
  output logic              alarm_en,
  output logic              alarm_ring
);
  localparam int PRESC_W   = $clog2(CLK_HZ + 1);
  localparam int RC_W      = $clog2(RING_SECS + 1);
  localparam int B_HOUR    = 0;
  localparam int B_MIN     = 1;
  localparam int B_AL_HOUR = 2;
  localparam int B_AL_MIN  = 3;
  localparam int B_ALARM   = 4;

  logic [4:0]         btn_raw;
  logic [4:0]         press;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               sec_carry;
  logic               min_carry;
  logic               time_edit;
  logic               alarm_match;
  logic [MIN_W-1:0]   second_n;
  logic [MIN_W-1:0]   minute_n;
  logic [MIN_W-1:0]   al_minute_n;
  logic [HOUR_W-1:0]  hour_n;
  logic [HOUR_W-1:0]  al_hour_n;
  alarm_state_t       state;
  alarm_state_t       state_n;
  logic [RC_W-1:0]    ring_cnt;
  logic [RC_W-1:0]    ring_cnt_n;
  logic               alarm_en_n;

  assign btn_raw = {btn_alarm, btn_al_min, btn_al_hour, btn_min, btn_hour};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  // A press adds one on top of whatever carry the tick delivers in the same cycle.
  always_comb begin
    tick        = (presc == PRESC_W'(CLK_HZ - 1));
    sec_carry   = tick && (second == MIN_W'(MINS_PER_HOUR - 1));
    min_carry   = sec_carry && (minute == MIN_W'(MINS_PER_HOUR - 1));
    second_n    = MIN_W'(wrap_add(WRAP_W'(second), WRAP_W'(tick), WRAP_W'(MINS_PER_HOUR)));
    minute_n    = MIN_W'(wrap_add(WRAP_W'(minute), WRAP_W'(sec_carry) + WRAP_W'(press[B_MIN]),
                                  WRAP_W'(MINS_PER_HOUR)));
    hour_n      = HOUR_W'(wrap_add(WRAP_W'(hour), WRAP_W'(min_carry) + WRAP_W'(press[B_HOUR]),
                                   WRAP_W'(HOURS_PER_DIAL)));
    al_hour_n   = HOUR_W'(wrap_add(WRAP_W'(al_hour), WRAP_W'(press[B_AL_HOUR]),
                                   WRAP_W'(HOURS_PER_DIAL)));
    al_minute_n = MIN_W'(wrap_add(WRAP_W'(al_minute),
                                  press[B_AL_MIN] ? WRAP_W'(AL_MIN_STEP) : '0,
                                  WRAP_W'(MINS_PER_HOUR)));
    time_edit   = |press[B_AL_MIN:B_HOUR];
    alarm_match = tick && alarm_en && !time_edit && (hour_n == al_hour) &&
                  (minute_n == al_minute) && (second_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      tick_1hz  <= 1'b0;
      slow_clk  <= 1'b0;
      second    <= '0;
      minute    <= '0;
      hour      <= '0;
      al_minute <= '0;
      al_hour   <= '0;
    end else begin
      presc     <= tick ? '0 : presc + 1'b1;
      tick_1hz  <= tick;
      slow_clk  <= (presc < PRESC_W'(CLK_HZ / 2));
      second    <= second_n;
      minute    <= minute_n;
      hour      <= hour_n;
      al_minute <= al_minute_n;
      al_hour   <= al_hour_n;
    end
  end

  // An alarm press always wins over a matching tick, so IDLE checks it first.
  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    alarm_en_n = alarm_en;
    case (state)
      ALARM_IDLE: begin
        if (press[B_ALARM]) begin
          alarm_en_n = !alarm_en;
        end else if (alarm_match) begin
          state_n    = ALARM_RING;
          ring_cnt_n = '0;
        end
      end
      ALARM_RING: begin
        if (press[B_ALARM] || !alarm_en) begin
          state_n = ALARM_IDLE;
        end else if (tick) begin
          if (ring_cnt == RC_W'(RING_SECS - 1)) state_n = ALARM_IDLE;
          else ring_cnt_n = ring_cnt + 1'b1;
        end
      end
      default: state_n = ALARM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ALARM_IDLE;
      ring_cnt   <= '0;
      alarm_en   <= 1'b0;
      alarm_ring <= 1'b0;
    end else begin
      state      <= state_n;
      ring_cnt   <= ring_cnt_n;
      alarm_en   <= alarm_en_n;
      alarm_ring <= (state_n == ALARM_RING);
    end
  end
endmodule
